i2c_cfg_master: RTL and testbench
=================================

# i2c_cfg_master

Parametrised I2C write master that sends one register-write transaction (slave address, register address, 1–4 data bytes) per request. The transaction is driven by a four-phase-per-bit sequencer with true open-drain SDA, ACK sampling and a request/ready handshake. It sits between the HDMI-transmitter configuration sequencer and the board SDA/SCL pins, and replaces the fixed address/control/data state chain.

## Interface
Parameters:
- CLK_DIV, 125: clk50 cycles per quarter-bit phase (125 → 100 kHz SCL); minimum 2.
- SLAVE_ADDR, 7'h39: 7-bit slave address; first byte is {SLAVE_ADDR,1'b0}.
- DATA_BYTES, 1: data bytes per transaction, 1..4.

Ports:
- clk50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted when start & ready.
- reg_addr  in  8  register address, latched on accept.
- wr_data  in  8*DATA_BYTES  data, latched on accept, MSB byte sent first.
- ready  out  1  idle, can accept.
- busy  out  1  transaction in progress (= ~ready).
- done  out  1  one-cycle pulse at transaction end.
- nack  out  1  last transaction saw a NACK; cleared on next accept.
- scl_o  out  1  SCL level.
- sda_oe  out  1  1 = pull SDA low, 0 = release.
- sda_in  in  1  SDA pin sample.

## Operation
- Reset values: ready=1, busy=0, done=0, nack=0, scl_o=1, sda_oe=0, state IDLE, phase 0, divider 0.
- States: IDLE → START → BIT → ACK → (BIT for next byte | STOP) → DONE → IDLE.
- Phase counter 0..3 advances on each divider tick.
- START phases (scl, sda): (1,1), (1,1), (1,0), (0,0).
- BIT phases: scl 0,1,1,0. SDA holds the current bit (MSB first) for all four phases.
- ACK phases: scl 0,1,1,0 with SDA released. sda_in is sampled on the tick that ends phase 2.
- STOP phases: (0,0), (1,0), (1,1), (1,1).
- Byte sequence: {SLAVE_ADDR,0}, reg_addr, then wr_data[8*DATA_BYTES-1 -: 8] down to wr_data[7:0].
- Byte count is 2+DATA_BYTES. A 3-bit bit counter and a 3-bit byte counter are sufficient.
- sda level 1 maps to sda_oe=0; level 0 maps to sda_oe=1.
- DONE lasts one cycle: done=1, then IDLE with ready=1.
- start while busy is ignored; inputs are not re-latched.
- Async reset mid-transaction: outputs return to reset values immediately. No STOP is generated.

## Timing
- Accept occurs in cycle 0. The divider clears on accept and ticks when count==CLK_DIV-1.
- Outputs are registered. Phase 0 of START appears in cycle 1, and each phase lasts exactly CLK_DIV cycles.
- Total phases: 4 + 36*(2+DATA_BYTES) + 4.
- done pulses in cycle 1 + phases*CLK_DIV.
- ready returns the cycle after done. A new start is accepted in that cycle.
- nack updates in the cycle after the sampling tick.

## Configuration
- Macro I2C_ACK_CHECK_EN.
- Defined: a NACK (sda_in=1 at the sample point) sets nack. The remaining bytes are skipped, the sequencer goes directly to STOP, and then done pulses.
- Undefined: ACK is never sampled and nack is tied 0. All bytes are sent regardless of the slave.

## Structure
- Package i2c_pkg holds:
  - the state enum (IDLE, START, BIT, ACK, STOP, DONE);
  - phase constants PH0..PH3;
  - function n_bytes(DATA_BYTES)=2+DATA_BYTES.
- Sub-module i2c_phase_tick holds the CLK_DIV counter with synchronous clear and a tick output.

## Test plan
- CLK_DIV=4, DATA_BYTES=1, reg 8'h98, data 8'h03, slave ACKs every byte → SDA decodes 0x72, 0x98, 0x03; START/STOP are well formed; done in cycle 465; nack=0.
- Same stimulus, but the slave NACKs the second byte (with I2C_ACK_CHECK_EN) → STOP follows that ACK slot, no data byte is sent, nack=1, done in cycle 1+(8+72)*4=321.
- DATA_BYTES=4, wr_data 32'hDEADBEEF → bytes 0x72, reg, DE, AD, BE, EF in order; done in cycle 1+224*4=897.
- start held high during busy → exactly one transaction. A second start in the cycle after done → back-to-back transaction with scl_o high in between.
- reset_n low at cycle 100 mid-byte → scl_o=1, sda_oe=0, ready=1 immediately. A start after reset completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C configuration write master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_t;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  function automatic int n_bytes(input int data_bytes);
    return 2 + data_bytes;
  endfunction

  // Bus levels {scl, sda} for a given state/phase; b is the data bit in BIT.
  function automatic logic [1:0] bus_levels(input state_t st, input logic [1:0] ph,
                                            input logic b);
    logic [1:0] lv;
    lv = 2'b11;
    case (st)
      START: begin
        case (ph)
          PH0, PH1: lv = 2'b11;
          PH2:      lv = 2'b10;
          default:  lv = 2'b00;
        endcase
      end
      BIT:  lv = {(ph == PH1) || (ph == PH2), b};
      ACK:  lv = {(ph == PH1) || (ph == PH2), 1'b1};
      STOP: begin
        case (ph)
          PH0:     lv = 2'b00;
          PH1:     lv = 2'b10;
          default: lv = 2'b11;
        endcase
      end
      default: lv = 2'b11;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_cfg_master_if.sv
// Request/handshake and pin-level signals of the I2C configuration master.
interface i2c_cfg_master_if #(
  parameter int DATA_BYTES = 1
);
  logic                      start;
  logic [7:0]                reg_addr;
  logic [8*DATA_BYTES-1:0]   wr_data;
  logic                      ready;
  logic                      busy;
  logic                      done;
  logic                      nack;
  logic                      scl_o;
  logic                      sda_oe;
  logic                      sda_in;

  modport master (
    input  start, reg_addr, wr_data, sda_in,
    output ready, busy, done, nack, scl_o, sda_oe
  );

  modport slave (
    output start, reg_addr, wr_data, sda_in,
    input  ready, busy, done, nack, scl_o, sda_oe
  );
endinterface

// File: rtl/i2c_phase_tick.sv
// Quarter-bit divider: o_tick marks the last clk50 cycle of each phase.
module i2c_phase_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk50,
  input  logic reset_n,
  input  logic i_clr,
  output logic o_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == TOP)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == TOP);

endmodule

// File: rtl/i2c_cfg_master.sv
// I2C register-write master: {addr,0}, reg_addr, DATA_BYTES data bytes per request.
// Define I2C_ACK_CHECK_EN to sample ACK and abort to STOP on a NACK.
module i2c_cfg_master
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 125,
  parameter logic [6:0] SLAVE_ADDR = 7'h39,
  parameter int         DATA_BYTES = 1
) (
  input logic              clk50,
  input logic              reset_n,
  i2c_cfg_master_if.master bus
);
  localparam int         NB   = n_bytes(DATA_BYTES);
  localparam logic [2:0] LAST = 3'(NB - 1);

  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_phase, w_phase_nxt;
  logic [2:0]              r_bit, w_bit_nxt;
  logic [2:0]              r_byte, w_byte_nxt;
  logic                    r_ready, r_done, r_nack, r_scl, r_sda_oe;
  logic                    w_nack_nxt;
  logic                    w_accept, w_tick;
  logic [7:0]              w_cur_byte;
  logic                    w_bit_val;
  logic [1:0]              w_lv;
  logic [7:0]              r_reg_addr;
  logic [8*DATA_BYTES-1:0] r_data;

  assign w_accept = r_ready & bus.start;

  i2c_phase_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk50   (clk50),
    .reset_n (reset_n),
    .i_clr   (w_accept),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk50) begin
    if (w_accept) begin
      r_reg_addr <= bus.reg_addr;
      r_data     <= bus.wr_data;
    end
  end

  // Byte k >= 2 maps to wr_data byte NB-1-k, so the MSB data byte goes first.
  always_comb begin
    w_cur_byte = 8'h00;
    if (w_byte_nxt == 3'd0) begin
      w_cur_byte = {SLAVE_ADDR, 1'b0};
    end else if (w_byte_nxt == 3'd1) begin
      w_cur_byte = r_reg_addr;
    end else begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        if (int'(w_byte_nxt) == NB - 1 - i) w_cur_byte = r_data[8*i +: 8];
      end
    end
  end

  assign w_bit_val = w_cur_byte[3'd7 - w_bit_nxt];

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_nack_nxt  = r_nack;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_phase_nxt = PH0;
          w_nack_nxt  = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_phase_nxt = r_phase + 2'd1;
          if (r_phase == PH3) begin
            w_state_nxt = BIT;
            w_bit_nxt   = 3'd0;
            w_byte_nxt  = 3'd0;
          end
        end
      end
      BIT: begin
        if (w_tick) begin
          w_phase_nxt = r_phase + 2'd1;
          if (r_phase == PH3) begin
            w_bit_nxt = r_bit + 3'd1;
            if (r_bit == 3'd7) w_state_nxt = ACK;
          end
        end
      end
      ACK: begin
        if (w_tick) begin
          w_phase_nxt = r_phase + 2'd1;
`ifdef I2C_ACK_CHECK_EN
          if ((r_phase == PH2) && bus.sda_in) w_nack_nxt = 1'b1;
          if (r_phase == PH3) begin
            if (r_nack || (r_byte == LAST)) begin
              w_state_nxt = STOP;
            end else begin
              w_state_nxt = BIT;
              w_byte_nxt  = r_byte + 3'd1;
              w_bit_nxt   = 3'd0;
            end
          end
`else
          if (r_phase == PH3) begin
            if (r_byte == LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_state_nxt = BIT;
              w_byte_nxt  = r_byte + 3'd1;
              w_bit_nxt   = 3'd0;
            end
          end
`endif
        end
      end
      STOP: begin
        if (w_tick) begin
          w_phase_nxt = r_phase + 2'd1;
          if (r_phase == PH3) w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_phase_nxt = PH0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifndef I2C_ACK_CHECK_EN
  logic w_unused_sda;
  assign w_unused_sda = bus.sda_in;
`endif

  assign w_lv = bus_levels(w_state_nxt, w_phase_nxt, w_bit_val);

  // Outputs are registered from the next-state decode so pins never glitch.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_phase  <= PH0;
      r_bit    <= 3'd0;
      r_byte   <= 3'd0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_nack   <= 1'b0;
      r_scl    <= 1'b1;
      r_sda_oe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_bit    <= w_bit_nxt;
      r_byte   <= w_byte_nxt;
      r_ready  <= (w_state_nxt == IDLE);
      r_done   <= (w_state_nxt == DONE);
      r_nack   <= w_nack_nxt;
      r_scl    <= w_lv[1];
      r_sda_oe <= ~w_lv[0];
    end
  end

  assign bus.ready  = r_ready;
  assign bus.busy   = ~r_ready;
  assign bus.done   = r_done;
  assign bus.nack   = r_nack;
  assign bus.scl_o  = r_scl;
  assign bus.sda_oe = r_sda_oe;

endmodule

// File: tb/tb_i2c_cfg_master.sv
// Randomized bench: a protocol-level I2C slave model decodes SDA/SCL of two masters (1 and 4 data bytes).
module tb_i2c_cfg_master;
  localparam int CLK_DIV = 4;
`ifdef I2C_ACK_CHECK_EN
  localparam bit ACKCHK = 1'b1;
`else
  localparam bit ACKCHK = 1'b0;
`endif

  logic clk50 = 1'b0;
  logic reset_n;
  logic pull;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk50 = ~clk50;

  i2c_cfg_master_if #(.DATA_BYTES(1)) b1 ();
  i2c_cfg_master_if #(.DATA_BYTES(4)) b4 ();

  i2c_cfg_master #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'h39), .DATA_BYTES(1)) dut1 (
    .clk50(clk50), .reset_n(reset_n), .bus(b1));
  i2c_cfg_master #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'h39), .DATA_BYTES(4)) dut4 (
    .clk50(clk50), .reset_n(reset_n), .bus(b4));

  // Wired-AND SDA: master pulls via sda_oe, slave model via pull.
  assign b1.sda_in = ~b1.sda_oe & ~pull;
  assign b4.sda_in = ~b4.sda_oe & ~pull;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input bit sel, input logic [7:0] ra, input logic [31:0] wd,
                         input int nb, input bit hold);
    int db, n, last, exp_done, done_cyc, cyc, w, bitpos, byte_idx, n_start, n_stop;
    bit fin, acking, exp_nack, prev_scl, prev_sda, scl, sda, oe, rdy, dn, nk, bsy;
    logic [7:0] sh;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    db = sel ? 4 : 1;
    n  = 2 + db;
    exp_q.push_back(8'h72);
    exp_q.push_back(ra);
    for (int i = db - 1; i >= 0; i--) exp_q.push_back(wd[8*i +: 8]);
    exp_nack = ACKCHK && (nb >= 0);
    last     = exp_nack ? nb : n - 1;
    exp_done = 1 + (8 + 36 * (last + 1)) * CLK_DIV;

    w = 0;
    while (!(sel ? b4.ready : b1.ready) && w < 2000) begin
      @(negedge clk50);
      w++;
    end
    check("ready_before_start", 32'(sel ? b4.ready : b1.ready), 32'd1);
    if (sel) begin
      b4.start = 1'b1; b4.reg_addr = ra; b4.wr_data = wd;
    end else begin
      b1.start = 1'b1; b1.reg_addr = ra; b1.wr_data = wd[7:0];
    end
    @(posedge clk50);
    cyc = 1; done_cyc = -1; fin = 0;
    prev_scl = 1'b1; prev_sda = 1'b1; bitpos = 0; byte_idx = 0; acking = 0;
    n_start = 0; n_stop = 0; sh = 8'h00;
    while (!fin) begin
      @(negedge clk50);
      scl = sel ? b4.scl_o  : b1.scl_o;
      oe  = sel ? b4.sda_oe : b1.sda_oe;
      rdy = sel ? b4.ready  : b1.ready;
      bsy = sel ? b4.busy   : b1.busy;
      dn  = sel ? b4.done   : b1.done;
      nk  = sel ? b4.nack   : b1.nack;
      sda = ~oe & ~pull;
      if (prev_scl && scl && prev_sda && !sda) begin
        n_start++;
        bitpos = 0;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        n_stop++;
      end
      if (!prev_scl && scl) begin
        if (bitpos < 8) sh = {sh[6:0], sda};
        bitpos++;
      end
      if (prev_scl && !scl) begin
        if (bitpos == 8 && !acking) begin
          got_q.push_back(sh);
          pull   = (byte_idx != nb);
          acking = 1;
        end else if (bitpos == 9) begin
          pull     = 1'b0;
          acking   = 0;
          bitpos   = 0;
          byte_idx++;
        end
      end
      if (cyc == 1) begin
        check("busy_cycle1", 32'(bsy), 32'd1);
        check("nack_cleared_on_accept", 32'(nk), 32'd0);
        if (hold) begin
          if (sel) begin b4.reg_addr = 8'($urandom); b4.wr_data = $urandom; end
          else begin b1.reg_addr = 8'($urandom); b1.wr_data = 8'($urandom); end
        end else begin
          if (sel) b4.start = 1'b0; else b1.start = 1'b0;
        end
      end
      if (dn && done_cyc < 0) begin
        done_cyc = cyc;
        check("ready_during_done", 32'(rdy), 32'd0);
        check("scl_high_at_done", 32'(scl), 32'd1);
      end else if (done_cyc >= 0) begin
        check("ready_after_done", 32'(rdy), 32'd1);
        check("done_one_cycle", 32'(dn), 32'd0);
        check("scl_high_between", 32'(scl), 32'd1);
        check("sda_released_idle", 32'(oe), 32'd0);
        check("nack_result", 32'(nk), 32'(exp_nack));
        fin = 1;
      end else if (cyc > exp_done + 20) begin
        fin = 1;
      end
      prev_scl = scl;
      prev_sda = sda;
      if (!fin) begin
        @(posedge clk50);
        cyc++;
      end
    end
    check("done_cycle", 32'(done_cyc), 32'(exp_done));
    check("byte_count", 32'(got_q.size()), 32'(last + 1));
    for (int i = 0; i <= last && i < got_q.size(); i++)
      check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("start_conditions", 32'(n_start), 32'd1);
    check("stop_conditions", 32'(n_stop), 32'd1);
  endtask

  initial begin
    bit sel;
    int n, nb;
    reset_n = 1'b0;
    pull = 1'b0;
    b1.start = 1'b0; b1.reg_addr = '0; b1.wr_data = '0;
    b4.start = 1'b0; b4.reg_addr = '0; b4.wr_data = '0;
    repeat (3) @(posedge clk50);
    @(negedge clk50);
    check("rst_ready", 32'(b1.ready), 32'd1);
    check("rst_busy", 32'(b1.busy), 32'd0);
    check("rst_done", 32'(b1.done), 32'd0);
    check("rst_nack", 32'(b1.nack), 32'd0);
    check("rst_scl", 32'(b1.scl_o), 32'd1);
    check("rst_sda_oe", 32'(b1.sda_oe), 32'd0);
    check("rst_ready4", 32'(b4.ready), 32'd1);
    check("rst_scl4", 32'(b4.scl_o), 32'd1);
    reset_n = 1'b1;
    @(negedge clk50);

    run_txn(1'b0, 8'h98, 32'h03, -1, 1'b0);
    run_txn(1'b0, 8'h98, 32'h03, 1, 1'b0);
    run_txn(1'b1, 8'h5A, 32'hDEADBEEF, -1, 1'b0);
    run_txn(1'b0, 8'($urandom), $urandom, -1, 1'b1);
    run_txn(1'b0, 8'($urandom), $urandom, -1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      sel = 1'($urandom_range(0, 1));
      n   = sel ? 6 : 3;
      nb  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_txn(sel, 8'($urandom), $urandom, nb, 1'($urandom_range(0, 1)));
    end
    b1.start = 1'b0;
    b4.start = 1'b0;

    // Mid-transaction asynchronous reset on the single-byte master.
    @(negedge clk50);
    b1.start = 1'b1; b1.reg_addr = 8'h11; b1.wr_data = 8'h22;
    @(negedge clk50);
    b1.start = 1'b0;
    repeat (99) @(negedge clk50);
    check("busy_before_reset", 32'(b1.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_scl", 32'(b1.scl_o), 32'd1);
    check("async_rst_sda_oe", 32'(b1.sda_oe), 32'd0);
    check("async_rst_ready", 32'(b1.ready), 32'd1);
    check("async_rst_busy", 32'(b1.busy), 32'd0);
    pull = 1'b0;
    @(negedge clk50);
    reset_n = 1'b1;
    @(negedge clk50);
    run_txn(1'b0, 8'h98, 32'h03, -1, 1'b0);
    b1.start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
